// File: rtl/ktane_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing the single ktane_mem port
// among the CPU, timer engine and event logger; read data returns in a register.
module ktane_bus_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int READ_LAT = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [16*NUM_REQ-1:0]  req_addr,
  input  logic [16*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     ack,
  output logic [15:0]            rdata,
  output logic [15:0]            mem_addr,
  output logic [15:0]            mem_data,
  output logic                   mem_we,
  input  logic [15:0]            mem_q
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   winner_reg;
  logic               we_reg;
  logic [1:0]         wait_cnt_reg;
  logic [15:0]        addr_reg;
  logic [15:0]        wdata_reg;
  logic [15:0]        rdata_reg;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;

  // Scan from the farthest offset down so the closest requester at/after rr_ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(rr_ptr_reg) + off) % NUM_REQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_valid) state_next = ISSUE;
      ISSUE:   state_next = we_reg ? ACK : WAIT;
      WAIT:    if (wait_cnt_reg == 2'd0) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      winner_reg   <= '0;
      we_reg       <= 1'b0;
      wait_cnt_reg <= 2'd0;
      addr_reg     <= 16'd0;
      wdata_reg    <= 16'd0;
      rdata_reg    <= 16'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          // The latched copy isolates the transaction from later requester input changes.
          if (pick_valid) begin
            winner_reg <= pick_idx;
            we_reg     <= req_we[pick_idx];
            addr_reg   <= req_addr[16*pick_idx +: 16];
            wdata_reg  <= req_wdata[16*pick_idx +: 16];
          end
        end
        ISSUE: wait_cnt_reg <= 2'(READ_LAT - 1);
        WAIT: begin
          if (wait_cnt_reg == 2'd0) rdata_reg <= mem_q;
          else wait_cnt_reg <= wait_cnt_reg - 2'd1;
        end
        ACK: begin
          rr_ptr_reg <= (winner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : winner_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = addr_reg;
  assign mem_data = wdata_reg;
  assign mem_we   = (state_reg == ISSUE) && we_reg;
  assign rdata    = rdata_reg;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_decode
    assign gnt[gi] = (state_reg != IDLE) && (winner_reg == IDX_W'(gi));
    assign ack[gi] = (state_reg == ACK) && (winner_reg == IDX_W'(gi));
  end

endmodule

// File: tb/tb_ktane_bus_arbiter.sv
// Bench for ktane_bus_arbiter: directed scenarios then random requesters, all
// checked every cycle against a transaction-timeline model of the arbiter.
module tb_ktane_bus_arbiter;

  localparam int NUM_REQ  = 3;
  localparam int READ_LAT = 3;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ-1:0]    req_we = '0;
  logic [16*NUM_REQ-1:0] req_addr = '0;
  logic [16*NUM_REQ-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    ack;
  logic [15:0]           rdata;
  logic [15:0]           mem_addr;
  logic [15:0]           mem_data;
  logic                  mem_we;
  logic [15:0]           mem_q;

  ktane_bus_arbiter #(.NUM_REQ(NUM_REQ), .READ_LAT(READ_LAT)) dut (
    .clock(clock), .reset(reset), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // Memory with a READ_LAT-deep read pipeline, driven only by the DUT port.
  logic        preload = 1'b0;
  logic [15:0] phys [256];
  logic [15:0] q_pipe [READ_LAT];
  assign mem_q = q_pipe[READ_LAT-1];

  function automatic logic [15:0] init_word(input int i);
    if (i == 16) return 16'h1234;
    return 16'(i * 311) ^ 16'hA5C3;
  endfunction

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) phys[i] <= init_word(i);
    end else if (mem_we) begin
      phys[mem_addr[7:0]] <= mem_data;
    end
    q_pipe[0] <= phys[mem_addr[7:0]];
    for (int k = 1; k < READ_LAT; k++) q_pipe[k] <= q_pipe[k-1];
  end

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  bit agent_en = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference model: one transaction at a time, described by its grant cycle and phase.
  bit          m_busy = 1'b0;
  int          m_g = 0;
  int          m_win = 0;
  bit          m_we = 1'b0;
  logic [15:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [15:0] exp_addr = '0, exp_data = '0;
  int          m_rr = 0;
  logic [15:0] model_mem [256];

  function automatic int ack_phase();
    return m_we ? 1 : 1 + READ_LAT;
  endfunction

  task automatic model_step();
    int ph;
    bit found;
    ph = cyc - m_g;
    if (m_busy && ph == 0 && m_we) model_mem[m_addr[7:0]] = m_wdata;
    if (reset) begin
      m_busy = 1'b0; m_rr = 0; m_rdata = '0; exp_addr = '0; exp_data = '0;
    end else if (m_busy) begin
      if (!m_we && ph == READ_LAT) m_rdata = model_mem[m_addr[7:0]];
      if (ph == ack_phase()) begin
        m_busy = 1'b0;
        m_rr = (m_win + 1) % NUM_REQ;
      end
    end else if (req != '0) begin
      found = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
        if (!found && req[(m_rr + off) % NUM_REQ]) begin
          found = 1'b1;
          m_win = (m_rr + off) % NUM_REQ;
        end
      end
      m_busy = 1'b1;
      m_g = cyc + 1;
      m_we = req_we[m_win];
      m_addr = req_addr[16*m_win +: 16];
      m_wdata = req_wdata[16*m_win +: 16];
      exp_addr = m_addr;
      exp_data = m_wdata;
    end
  endtask

  task automatic compare_all();
    int ph;
    logic [15:0] e_gnt, e_ack, e_we;
    ph = cyc - m_g;
    e_gnt = m_busy ? 16'(1 << m_win) : 16'd0;
    e_ack = (m_busy && ph == ack_phase()) ? 16'(1 << m_win) : 16'd0;
    e_we  = (m_busy && ph == 0 && m_we) ? 16'd1 : 16'd0;
    check("gnt", 16'(gnt), e_gnt);
    check("ack", 16'(ack), e_ack);
    check("mem_we", 16'(mem_we), e_we);
    check("mem_addr", mem_addr, exp_addr);
    check("mem_data", mem_data, exp_data);
    check("rdata", rdata, m_rdata);
  endtask

  task automatic raise(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[16*i +: 16] = a;
    req_wdata[16*i +: 16] = d;
  endtask

  task automatic raise_rand(input int i);
    raise(i, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
  endtask

  task automatic agents();
    reset = ($urandom_range(0, 399) == 0);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && ack[i]) begin
        req[i] = 1'b0;
        if ($urandom_range(0, 1) == 1) raise_rand(i);
      end else if (req[i] && gnt[i]) begin
        case ($urandom_range(0, 7))
          0: req[i] = 1'b0;
          1, 2: begin
            req_we[i] = ~req_we[i];
            req_addr[16*i +: 16] = 16'($urandom);
            req_wdata[16*i +: 16] = 16'($urandom);
          end
          default: ;
        endcase
      end else if (!req[i] && $urandom_range(0, 3) == 0) begin
        raise_rand(i);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    cyc++;
    @(negedge clock);
    compare_all();
    if (ack != '0)
      $display("txn cyc=%0d ack=%b we=%0b addr=%h wdata=%h rdata=%h",
               cyc, ack, m_we, m_addr, m_wdata, rdata);
    if (agent_en) agents();
  endtask

  task automatic wait_any_gnt(input string tag);
    int n = 0;
    while (gnt == '0 && n < 50) begin tick(); n++; end
    check(tag, 16'(gnt != '0), 16'd1);
  endtask

  task automatic wait_no_gnt(input string tag);
    int n = 0;
    while (gnt != '0 && n < 50) begin tick(); n++; end
    check(tag, 16'(gnt), 16'd0);
  endtask

  task automatic wait_ack(input int idx, input string tag);
    int n = 0;
    while (!ack[idx] && n < 50) begin tick(); n++; end
    check(tag, 16'(ack[idx]), 16'd1);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    preload = 1'b1;
    do_reset(3);
    preload = 1'b0;
    check("rst_gnt", 16'(gnt), 16'd0);
    check("rst_rdata", rdata, 16'd0);
    check("rst_mem_addr", mem_addr, 16'd0);

    // Single write from requester 1
    raise(1, 1'b1, 16'h0040, 16'hBEEF);
    wait_any_gnt("wr_gnt_wait");
    check("wr_gnt", 16'(gnt), 16'b010);
    check("wr_mem_we", 16'(mem_we), 16'd1);
    check("wr_mem_addr", mem_addr, 16'h0040);
    check("wr_mem_data", mem_data, 16'hBEEF);
    tick();
    check("wr_ack", 16'(ack), 16'b010);
    check("wr_rdata", rdata, 16'd0);
    req[1] = 1'b0;
    tick();

    // Single read from requester 0
    raise(0, 1'b0, 16'h0010, 16'h0000);
    wait_any_gnt("rd_gnt_wait");
    check("rd_gnt", 16'(gnt), 16'b001);
    check("rd_mem_we", 16'(mem_we), 16'd0);
    wait_ack(0, "rd_ack_wait");
    check("rd_ack", 16'(ack), 16'b001);
    check("rd_rdata", rdata, 16'h1234);
    req[0] = 1'b0;
    tick();

    // Round robin with all requests held
    do_reset(2);
    for (int i = 0; i < NUM_REQ; i++) raise(i, 1'b1, 16'(32 + i), 16'(16'h0100 * (i + 1)));
    for (int k = 0; k < 6; k++) begin
      wait_any_gnt("rr_gnt_wait");
      check("rr_order", 16'(gnt), 16'(1 << (k % NUM_REQ)));
      wait_no_gnt("rr_release");
    end
    req = '0;
    tick();
    wait_no_gnt("rr_drain");

    // Requester input change after the grant edge
    raise(2, 1'b0, 16'h0005, 16'h0000);
    wait_any_gnt("chg_gnt_wait");
    check("chg_gnt", 16'(gnt), 16'b100);
    req_addr[32 +: 16] = 16'h00FF;
    check("chg_addr_issue", mem_addr, 16'h0005);
    wait_ack(2, "chg_ack_wait");
    check("chg_addr_ack", mem_addr, 16'h0005);
    req[2] = 1'b0;
    tick();

    // Request dropped during ISSUE of a write
    do_reset(1);
    raise(1, 1'b1, 16'h0030, 16'h7777);
    raise(2, 1'b1, 16'h0031, 16'h8888);
    wait_any_gnt("drop_gnt_wait");
    check("drop_gnt", 16'(gnt), 16'b010);
    req[1] = 1'b0;
    wait_ack(1, "drop_ack_wait");
    tick();
    wait_any_gnt("drop_next_wait");
    check("drop_next_gnt", 16'(gnt), 16'b100);
    check("drop_mem_written", phys[8'h30], 16'h7777);
    wait_ack(2, "drop_ack2_wait");
    req[2] = 1'b0;
    tick();

    // Reset during a read's WAIT phase
    raise(0, 1'b0, 16'h0010, 16'h0000);
    wait_ack(0, "mr_pre_ack");
    check("mr_pre_rdata", rdata, 16'h1234);
    req[0] = 1'b0;
    tick();
    raise(1, 1'b0, 16'h0007, 16'h0000);
    wait_any_gnt("mr_gnt_wait");
    check("mr_gnt", 16'(gnt), 16'b010);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req[1] = 1'b0;
    check("mr_gnt_after", 16'(gnt), 16'd0);
    check("mr_rdata", rdata, 16'd0);
    check("mr_mem_we", 16'(mem_we), 16'd0);
    repeat (6) begin
      tick();
      check("mr_no_ack", 16'(ack), 16'd0);
    end
    raise(0, 1'b0, 16'h0003, 16'h0000);
    raise(1, 1'b0, 16'h0004, 16'h0000);
    wait_any_gnt("mr_first_wait");
    check("mr_first_gnt", 16'(gnt), 16'b001);
    wait_ack(0, "mr_ack0");
    req[0] = 1'b0;
    wait_ack(1, "mr_ack1");
    req[1] = 1'b0;
    tick();

    // Randomized requesters with occasional reset
    agent_en = 1'b1;
    repeat (3000) tick();
    agent_en = 1'b0;
    reset = 1'b0;
    req = '0;
    repeat (30) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
